// File: rtl/fram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fram_arb_pkg                                                               |
// | Shared types and constants for the FRAM access arbiter.                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fram_arb_pkg;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } arb_state_t;

    // Device type nibble of the FM24CLxx slave address, shared with the driver.
    localparam logic [3:0] FRAM_DEV_TYPE_ID = 4'b1010;

    localparam int DEF_BUSY_WAIT_MAX = 8;
    localparam int DEF_OP_WAIT_MAX   = 65535;

endpackage : fram_arb_pkg
`default_nettype wire

// File: rtl/fram_access_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Combinational round-robin grant: first request at or after the pointer.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic               o_gnt_valid,
    output logic [PTR_W-1:0]   o_gnt_idx
);

    logic [PTR_W-1:0] w_sel;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_sel       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sel = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
            if (i_req[w_sel]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_sel;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fram_access_arbiter                                                        |
// | Round-robin sharing of one FM24CLxx FRAM driver among NUM_REQ requesters.  |
// | Optional: FRAM_ARB_TIMEOUT_EN adds busy/operation timeouts and resp_err.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fram_access_arbiter
    import fram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BUSY_WAIT_MAX = DEF_BUSY_WAIT_MAX,
    parameter int OP_WAIT_MAX   = DEF_OP_WAIT_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_write,
    input  logic [NUM_REQ*8-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [7:0]           resp_rdata,
    output logic                 resp_err,
    output logic                 drv_start,
    output logic [7:0]           drv_mem_address,
    output logic [7:0]           drv_data_in,
    output logic                 drv_write_enable,
    output logic                 drv_read_enable,
    input  logic                 drv_busy,
    input  logic [7:0]           drv_data_out,
    input  logic                 drv_rd_beat
);

    localparam int                 c_PTR_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE   = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_WAIT_MAX < 1 ||
        OP_WAIT_MAX < 1 || OP_WAIT_MAX > 65536) begin : g_param_check
        $error("fram_access_arbiter: parameter out of range");
    end

    arb_state_t         r_state;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_gnt;
    logic               r_write;
    logic [7:0]         r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_rdata;

    logic               w_gnt_valid;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic               w_drv_active;
    logic [7:0]         w_addr_arr  [NUM_REQ];
    logic [7:0]         w_wdata_arr [NUM_REQ];

`ifdef FRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] c_BUSY_LIM = 16'(BUSY_WAIT_MAX - 1);
    localparam logic [15:0] c_OP_LIM   = 16'(OP_WAIT_MAX - 1);

    logic        r_err;
    logic [15:0] r_cnt;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[8*gi +: 8];
        assign w_wdata_arr[gi] = req_wdata[8*gi +: 8];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign w_ptr_next = (w_gnt_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Driver inputs are held from LAUNCH through WAIT_DONE; the driver
    // re-samples the enables partway through its sequence.
    assign w_drv_active = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_BUSY) ||
                          (r_state == ST_WAIT_DONE);

    assign req_ready        = (r_state == ST_ARB && w_gnt_valid && !rst) ? (c_ONE << w_gnt_idx) : '0;
    assign resp_valid       = (r_state == ST_RESP) ? (c_ONE << r_gnt) : '0;
    assign resp_rdata       = (r_state == ST_RESP) ? r_rdata : 8'h00;
    assign drv_start        = (r_state == ST_LAUNCH);
    assign drv_mem_address  = w_drv_active ? r_addr : 8'h00;
    assign drv_data_in      = w_drv_active ? r_wdata : 8'h00;
    assign drv_write_enable = w_drv_active & r_write;
    assign drv_read_enable  = w_drv_active & ~r_write;

`ifdef FRAM_ARB_TIMEOUT_EN
    assign resp_err = (r_state == ST_RESP) & r_err;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
`ifdef FRAM_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
            r_cnt   <= 16'h0000;
`endif
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_gnt_valid) begin
                        r_gnt   <= w_gnt_idx;
                        r_ptr   <= w_ptr_next;
                        r_write <= req_write[w_gnt_idx];
                        r_addr  <= w_addr_arr[w_gnt_idx];
                        r_wdata <= w_wdata_arr[w_gnt_idx];
                        r_rdata <= 8'h00;
`ifdef FRAM_ARB_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
`ifdef FRAM_ARB_TIMEOUT_EN
                    r_cnt   <= 16'h0000;
`endif
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (drv_busy) begin
`ifdef FRAM_ARB_TIMEOUT_EN
                        r_cnt   <= 16'h0000;
`endif
                        r_state <= ST_WAIT_DONE;
                    end
`ifdef FRAM_ARB_TIMEOUT_EN
                    else if (r_cnt == c_BUSY_LIM) begin
                        r_err   <= 1'b1;
                        r_rdata <= 8'h00;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'h0001;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    // drv_data_out is only meaningful during the read beat.
                    if (!r_write && drv_rd_beat) begin
                        r_rdata <= drv_data_out;
                    end
                    if (!drv_busy) begin
                        r_state <= ST_RESP;
                    end
`ifdef FRAM_ARB_TIMEOUT_EN
                    else if (r_cnt == c_OP_LIM) begin
                        r_err   <= 1'b1;
                        r_rdata <= 8'h00;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'h0001;
                    end
`endif
                end
                ST_RESP: begin
                    if (resp_ready[r_gnt]) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

endmodule : fram_access_arbiter
`default_nettype wire

// File: tb/tb_fram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fram_access_arbiter                                                     |
// | Directed vectors plus hand-written sequences with a simple driver model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fram_access_arbiter;

    localparam int NR   = 4;
    localparam int BLEN = 4;   // model busy length in cycles

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [NR*8-1:0] req_addr, req_wdata;
    logic [7:0]    resp_rdata, drv_mem_address, drv_data_in, drv_data_out;
    logic          resp_err, drv_start, drv_write_enable, drv_read_enable;
    logic          drv_busy, drv_rd_beat;

    logic          m_busy, man_busy, stuck;
    int            beat_at;
    logic [7:0]    rd_data;
    int            n_checks = 0;
    int            n_errors = 0;

    assign drv_busy = stuck ? man_busy : m_busy;

    always #5 clk = ~clk;

    fram_access_arbiter #(.NUM_REQ(NR)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .drv_start        (drv_start),
        .drv_mem_address  (drv_mem_address),
        .drv_data_in      (drv_data_in),
        .drv_write_enable (drv_write_enable),
        .drv_read_enable  (drv_read_enable),
        .drv_busy         (drv_busy),
        .drv_data_out     (drv_data_out),
        .drv_rd_beat      (drv_rd_beat)
    );

    // Driver model: busy from start+2 for BLEN cycles, read beat at offset beat_at.
    initial begin
        bit m_act;
        bit m_rd;
        int m_c;
        m_act = 1'b0; m_rd = 1'b0; m_c = 0;
        m_busy = 1'b0; drv_rd_beat = 1'b0; drv_data_out = 8'hEE;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_act = 1'b0; m_busy = 1'b0; drv_rd_beat = 1'b0; drv_data_out = 8'hEE;
            end else begin
                if (m_act) m_c++;
                if (drv_start && !m_act) begin
                    m_act = 1'b1; m_c = 0; m_rd = drv_read_enable;
                end
                m_busy       = m_act && (m_c >= 2) && (m_c < 2 + BLEN);
                drv_rd_beat  = m_act && m_rd && (m_c == beat_at);
                drv_data_out = drv_rd_beat ? rd_data : 8'hEE;
                if (m_act && m_c >= 2 + BLEN) m_act = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         idx;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] mdata;
        int         beat;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int idx, input string name);
        int k = 0;
        @(negedge clk);
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(req_ready), 64'(1) << idx);
    endtask

    task automatic wait_resp(input int idx, input string name);
        int k = 0;
        @(negedge clk);
        while (resp_valid == '0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(resp_valid), 64'(1) << idx);
    endtask

    task automatic accept(input int idx);
        resp_ready[idx] = 1'b1;
        @(posedge clk); #1;
        resp_ready[idx] = 1'b0;
    endtask

    task automatic set_req(input int idx, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        req_write[idx]       = wr;
        req_addr[8*idx +: 8] = addr;
        req_wdata[8*idx +: 8] = wdata;
        req_valid[idx]       = 1'b1;
    endtask

    task automatic do_vec(input int n, input vec_t v);
        beat_at = v.beat;
        rd_data = v.mdata;
        set_req(v.idx, v.wr, v.addr, v.wdata);
        wait_grant(v.idx, $sformatf("v%0d_grant", n));
        @(posedge clk); #1;
        req_valid[v.idx] = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_start", n), 64'(drv_start), 64'd1);
        check($sformatf("v%0d_enables", n), {drv_write_enable, drv_read_enable}, {v.wr, ~v.wr});
        check($sformatf("v%0d_addr", n), drv_mem_address, v.addr);
        if (v.wr) check($sformatf("v%0d_wdata", n), drv_data_in, v.wdata);
        @(negedge clk);
        check($sformatf("v%0d_hold", n), {drv_start, drv_mem_address, drv_write_enable, drv_read_enable},
              {1'b0, v.addr, v.wr, ~v.wr});
        wait_resp(v.idx, $sformatf("v%0d_resp_valid", n));
        check($sformatf("v%0d_rdata", n), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", n), 64'(resp_err), 64'd0);
        check($sformatf("v%0d_drv_idle", n), {drv_write_enable, drv_read_enable, drv_start}, 3'b000);
        accept(v.idx);
    endtask

    // Wait for grant, release the request, then complete the response.
    task automatic serve(input int idx, input string name);
        wait_grant(idx, {name, "_grant"});
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        wait_resp(idx, {name, "_resp"});
        accept(idx);
    endtask

    initial begin
        logic bad;

        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; resp_ready = '0;
        man_busy = 1'b0; stuck = 1'b0; beat_at = 5; rd_data = 8'h00;

        vecs[0] = '{1, 1'b1, 8'h3C, 8'hA5, 8'h00, 5, 8'h00};
        vecs[1] = '{2, 1'b0, 8'h10, 8'h00, 8'h5A, 5, 8'h5A};
        vecs[2] = '{0, 1'b0, 8'hFF, 8'h00, 8'h81, 6, 8'h81};  // beat with busy falling
        vecs[3] = '{3, 1'b0, 8'h00, 8'h00, 8'h33, 3, 8'h33};  // first WAIT_DONE cycle
        vecs[4] = '{3, 1'b1, 8'h7E, 8'h00, 8'h99, 5, 8'h00};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {req_ready, resp_valid, resp_rdata, resp_err, drv_start, drv_mem_address,
               drv_data_in, drv_write_enable, drv_read_enable}, 36'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) do_vec(i, vecs[i]);

        // Fairness: all requesters held valid; expect 0,1,2,3,0,1,2,3.
        beat_at = 5;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'h40 + i), 8'(i));
        resp_ready = '1;
        for (int j = 0; j < 8; j++) begin
            wait_grant(j % NR, $sformatf("fair%0d_grant", j));
            @(negedge clk);
            check($sformatf("fair%0d_addr", j), drv_mem_address, 64'(8'h40 + (j % NR)));
        end
        req_valid = '0;
        wait_resp(3, "fair_last_resp");
        @(posedge clk); #1;
        resp_ready = '0;

        // Backpressure: hold response 10 cycles with other ready lines high.
        rd_data = 8'hC7;
        set_req(0, 1'b0, 8'h22, 8'h00);
        wait_grant(0, "bp_grant");
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 8'h55, 8'h66);
        wait_resp(0, "bp_resp");
        resp_ready = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", k), {resp_valid, resp_rdata, drv_start, req_ready},
                  {4'b0001, 8'hC7, 1'b0, 4'b0000});
        end
        resp_ready = 4'b0001;
        @(posedge clk); #1;
        resp_ready = '0;
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_resp(1, "bp_next_resp");
        accept(1);

        // Driver never raises busy.
        stuck = 1'b1; man_busy = 1'b0;
        set_req(0, 1'b0, 8'h99, 8'h00);
        wait_grant(0, "stuck_grant");
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("stuck_start", 64'(drv_start), 64'd1);
`ifdef FRAM_ARB_TIMEOUT_EN
        bad = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid != '0) bad = 1'b1;
        end
        check("to_no_early_resp", 64'(bad), 64'd0);
        @(negedge clk);
        check("to_resp", {resp_valid, resp_err, resp_rdata}, {4'b0001, 1'b1, 8'h00});
        accept(0);
`else
        bad = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid != '0 || drv_read_enable != 1'b1 || drv_mem_address != 8'h99) bad = 1'b1;
        end
        check("stuck_waits", 64'(bad), 64'd0);
        man_busy = 1'b1;
        @(negedge clk);
        man_busy = 1'b0;
        wait_resp(0, "stuck_resp");
        check("stuck_rdata_err", {resp_rdata, resp_err}, {8'h00, 1'b0});
        accept(0);
`endif
        stuck = 1'b0;

        // Reset in WAIT_DONE, then pointer must restart at 0.
        rd_data = 8'h11; beat_at = 5;
        set_req(2, 1'b0, 8'h44, 8'h00);
        wait_grant(2, "rst_grant");
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_in_wait_done", {drv_busy, drv_read_enable}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs",
              {req_ready, resp_valid, resp_rdata, resp_err, drv_start, drv_mem_address,
               drv_data_in, drv_write_enable, drv_read_enable}, 36'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        set_req(1, 1'b1, 8'h01, 8'h02);
        set_req(3, 1'b1, 8'h03, 8'h04);
        serve(1, "post_rst1");
        serve(3, "post_rst3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fram_access_arbiter
`default_nettype wire

// File: doc/fram_access_arbiter.md
Name: fram_access_arbiter

Overview:
- Shares one FM24CLxx FRAM access driver among NUM_REQ independent requesters. The driver exposes start, mem_address, data_in, write_enable, read_enable, busy and data_out.
- Arbitrates requests round-robin and sequences each single-byte read or write through the driver's start/busy protocol.
- Captures read data and returns a per-requester response with a valid/ready handshake.
- Sits between user logic (register banks, config loaders) and the FRAM driver / I2C master pair.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- BUSY_WAIT_MAX, 8, max cycles from drv_start until drv_busy is seen high.
- OP_WAIT_MAX, 65535, max cycles drv_busy may stay high per operation (timeout build only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*8  packed word addresses; requester i at [8i+7:8i]
- req_wdata  in  NUM_REQ*8  packed write data
- resp_valid  out  NUM_REQ  one-hot response valid
- resp_ready  in  NUM_REQ  per-requester response ready
- resp_rdata  out  8  read data (shared; qualified by resp_valid)
- resp_err  out  1  response error flag (timeout build only; tied 0 otherwise)
- drv_start  out  1  driver start pulse
- drv_mem_address  out  8  to driver mem_address
- drv_data_in  out  8  to driver data_in
- drv_write_enable  out  1  to driver write_enable
- drv_read_enable  out  1  to driver read_enable
- drv_busy  in  1  driver busy
- drv_data_out  in  8  driver data_out (valid only during the read beat)
- drv_rd_beat  in  1  m_axis_data_tvalid & m_axis_data_tready from the I2C master

Behaviour:
- Reset: all outputs 0, FSM in ARB, round-robin pointer = 0.
- FSM states: ARB -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> RESP -> ARB.
- ARB:
  - Pick the first asserted req_valid at or after the pointer, wrapping modulo NUM_REQ.
  - Pulse req_ready[g] for exactly 1 cycle.
  - Latch write, addr and wdata into internal registers; latch grant index g.
  - Pointer <= (g+1) mod NUM_REQ.
  - No valid request: stay in ARB, pointer unchanged.
- LAUNCH:
  - drv_start = 1 for exactly 1 cycle.
  - drv_mem_address, drv_data_in and drv_write_enable/drv_read_enable are driven from the latched registers.
  - These driver inputs stay stable from LAUNCH until leaving WAIT_DONE, because the driver samples enables mid-sequence.
  - Exactly one of the two enables is high; both are 0 in all other states.
- WAIT_BUSY:
  - Wait for drv_busy = 1; the driver raises busy 2 cycles after start.
  - Move to WAIT_DONE on busy.
- WAIT_DONE:
  - For a read, capture drv_data_out into the rdata register in the cycle drv_rd_beat = 1. This is the only cycle drv_data_out is valid.
  - drv_busy = 0 -> RESP.
  - Busy falling in the same cycle as the read beat: capture, then RESP.
  - Write op: rdata register holds 0x00.
- RESP:
  - resp_valid[g] = 1; resp_rdata = captured byte.
  - Hold until resp_ready[g] = 1, then go to ARB the next cycle.
  - Transfer occurs when resp_valid and resp_ready are both high in the same cycle.
  - resp_ready on other lines is ignored.
- Latency: idle requester i granted on accept cycle T gives drv_start at T+1. Minimum accept-to-next-accept is driver time + 4 cycles.
- Simultaneous requests: exactly one grant; the others remain pending (requesters hold req_valid and payload until req_ready).
- req_valid dropped before grant: no grant, no effect.
- BUSY_WAIT_MAX exceeded in WAIT_BUSY (driver never started): go to RESP with resp_err = 1 (timeout build); else keep waiting.
- rst mid-operation: FSM -> ARB, pointer 0, all outputs 0 next cycle. The driver is reset by the same rst.

Optional Feature:
- FRAM_ARB_TIMEOUT_EN defined:
  - A 16-bit cycle counter runs in WAIT_BUSY (limit BUSY_WAIT_MAX) and in WAIT_DONE (limit OP_WAIT_MAX).
  - Expiry -> RESP with resp_err = 1 and resp_rdata = 0x00; the counter clears on state entry.
- Not defined:
  - No counters; both wait states wait indefinitely.
  - resp_err is tied 0.

Decomposition:
- Package fram_arb_pkg:
  - arb_state_t enum.
  - localparam FRAM_DEV_TYPE_ID = 4'b1010, shared with the driver.
  - Default timeout constants.
- One sub-module rr_arbiter: combinational round-robin grant from request vector and pointer, NUM_REQ-parameterised. The pointer register stays in the parent.

Test Plan:
- Single write: req 1 writes addr 0x3C, data 0xA5 -> req_ready[1] pulses; drv_start next cycle with mem_address 0x3C, data_in 0xA5, write_enable 1; after busy falls, resp_valid[1], resp_err 0.
- Single read: req 2 reads addr 0x10; driver model returns 0x5A on drv_rd_beat -> resp_rdata 0x5A with resp_valid[2].
- Fairness: all 4 requesters valid continuously -> grant order 0,1,2,3,0; no starvation over 8 ops.
- Backpressure: resp_ready[0] held low 10 cycles -> resp_valid[0] and resp_rdata stable; no new drv_start until acceptance.
- Mid-op reset: assert rst in WAIT_DONE -> all outputs 0 next cycle; a subsequent request from requester 3 is granted (pointer 0 search wraps correctly).
- Timeout (FRAM_ARB_TIMEOUT_EN): drv_busy stuck 0 after start -> resp_err 1 after BUSY_WAIT_MAX = 8 cycles, resp_rdata 0x00.
